bus_arbiter_rr: RTL and testbench

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

---
 rtl/bus_arbiter_rr.sv | 185 ++++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin master/slave bus arbiter with a serial slave-select prefix.
// Optional tenure watchdog: define ARB_TIMEOUT_EN to force release after TIMEOUT cycles.
module bus_arbiter_rr #(
  parameter int NUM_M   = 4,
  parameter int NUM_S   = 3,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NUM_M-1:0] m_request,
  input  logic [NUM_M-1:0] m_address,
  input  logic [NUM_M-1:0] m_address_valid,
  input  logic [NUM_M-1:0] m_data,
  input  logic [NUM_M-1:0] m_valid,
  input  logic [NUM_M-1:0] m_write_en,
  input  logic [NUM_M-1:0] m_burst,
  output logic [NUM_M-1:0] m_available,
  output logic [NUM_M-1:0] m_ready,
  output logic [NUM_M-1:0] m_data_out,
  output logic [NUM_M-1:0] m_valid_in,
  output logic [NUM_S-1:0] s_address,
  output logic [NUM_S-1:0] s_data,
  output logic [NUM_S-1:0] s_valid,
  output logic [NUM_S-1:0] s_write_en,
  output logic [NUM_S-1:0] s_burst,
  output logic [NUM_S-1:0] bus_ready_s,
  input  logic [NUM_S-1:0] s_ready,
  input  logic [NUM_S-1:0] s_data_in,
  input  logic [NUM_S-1:0] s_valid_out,
  input  logic [NUM_S-1:0] s_hold,
  output logic [1:0]       state,
  output logic [2:0]       grant_id,
  output logic             decode_err,
  output logic             timeout_err
);

  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW = $clog2(SEL_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, CONNECT = 2'd2, HOLD = 2'd3} state_t;

  state_t          cur_st, nxt_st;
  logic [MW-1:0]   g, g_n, last, last_n, win;
  logic [SEL_W-1:0] sel, sel_n, sel_shift;
  logic [CW-1:0]   bcnt, bcnt_n;
  logic            derr_n, terr_n, routing;

  assign state    = cur_st;
  assign routing  = (cur_st == CONNECT) || (cur_st == HOLD);
  assign grant_id = (cur_st != IDLE) ? 3'(g) : 3'd0;
  assign m_available = (cur_st != IDLE) ? (NUM_M'(1) << g) : '0;
  assign bus_ready_s = routing ? (NUM_S'(1) << sel) : '0;
  assign sel_shift   = SEL_W'({sel, m_address[g]});

  // First requester strictly after the last grant, wrapping around.
  always_comb begin
    int idx;
    logic found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx = (int'(last) + k) % NUM_M;
      if (!found && m_request[idx]) begin
        win   = MW'(idx);
        found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] tcnt;
  logic        to_hit;
  assign to_hit = (cur_st != IDLE) && (tcnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset)                tcnt <= '0;
    else if (cur_st == IDLE)  tcnt <= '0;
    else                      tcnt <= tcnt + 16'd1;
  end
`else
  logic to_hit;
  logic timeout_unused;
  assign to_hit         = 1'b0;
  assign timeout_unused = (TIMEOUT > 0);
`endif

  always_comb begin
    nxt_st = cur_st;
    g_n    = g;
    last_n = last;
    sel_n  = sel;
    bcnt_n = bcnt;
    derr_n = 1'b0;
    terr_n = 1'b0;
    case (cur_st)
      IDLE: if (|m_request) begin
        nxt_st = ADDR;
        g_n    = win;
        sel_n  = '0;
        bcnt_n = '0;
      end
      ADDR: begin
        if (!m_request[g]) begin
          nxt_st = IDLE;
          last_n = g;
        end else if (m_address_valid[g]) begin
          sel_n = sel_shift;
          if (bcnt == CW'(SEL_W - 1)) begin
            if (int'(sel_shift) < NUM_S) nxt_st = CONNECT;
            else begin
              nxt_st = IDLE;
              derr_n = 1'b1;
              last_n = g;
            end
          end else begin
            bcnt_n = bcnt + CW'(1);
          end
        end
      end
      CONNECT: if (!m_request[g]) begin
        if (s_hold[sel]) nxt_st = HOLD;
        else begin
          nxt_st = IDLE;
          last_n = g;
        end
      end
      HOLD: if (!s_hold[sel]) begin
        nxt_st = IDLE;
        last_n = g;
      end
      default: nxt_st = IDLE;
    endcase
    // Watchdog overrides everything, including a slave hold.
    if (to_hit) begin
      nxt_st = IDLE;
      last_n = g;
      derr_n = 1'b0;
      terr_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_st      <= IDLE;
      g           <= '0;
      last        <= MW'(NUM_M - 1);
      sel         <= '0;
      bcnt        <= '0;
      decode_err  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cur_st      <= nxt_st;
      g           <= g_n;
      last        <= last_n;
      sel         <= sel_n;
      bcnt        <= bcnt_n;
      decode_err  <= derr_n;
      timeout_err <= terr_n;
    end
  end

  // Zero-latency crossbar, only live while a slave is connected.
  always_comb begin
    s_address  = '0;
    s_data     = '0;
    s_valid    = '0;
    s_write_en = '0;
    s_burst    = '0;
    m_ready    = '0;
    m_data_out = '0;
    m_valid_in = '0;
    if (routing) begin
      s_address[sel]  = m_address[g];
      s_data[sel]     = m_data[g];
      s_valid[sel]    = m_valid[g];
      s_write_en[sel] = m_write_en[g];
      s_burst[sel]    = m_burst[g];
      m_ready[g]      = s_ready[sel];
      m_data_out[g]   = s_data_in[sel];
      m_valid_in[g]   = s_valid_out[sel];
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Randomized self-checking bench for bus_arbiter_rr against a round-robin reference model.
module tb_bus_arbiter_rr;
  localparam int NM = 4;
  localparam int NS = 3;
  localparam int SW = 2;

  logic clk = 0, reset = 0;
  logic [NM-1:0] m_request = '0, m_address = '0, m_address_valid = '0, m_data = '0;
  logic [NM-1:0] m_valid = '0, m_write_en = '0, m_burst = '0;
  logic [NM-1:0] m_available, m_ready, m_data_out, m_valid_in;
  logic [NS-1:0] s_address, s_data, s_valid, s_write_en, s_burst, bus_ready_s;
  logic [NS-1:0] s_ready = '0, s_data_in = '0, s_valid_out = '0, s_hold = '0;
  logic [1:0] state;
  logic [2:0] grant_id;
  logic decode_err, timeout_err;

  int checks = 0, errors = 0;
  int lg;  // model of last granted master

  bus_arbiter_rr #(.NUM_M(NM), .NUM_S(NS), .SEL_W(SW), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset),
    .m_request(m_request), .m_address(m_address), .m_address_valid(m_address_valid),
    .m_data(m_data), .m_valid(m_valid), .m_write_en(m_write_en), .m_burst(m_burst),
    .m_available(m_available), .m_ready(m_ready), .m_data_out(m_data_out), .m_valid_in(m_valid_in),
    .s_address(s_address), .s_data(s_data), .s_valid(s_valid), .s_write_en(s_write_en),
    .s_burst(s_burst), .bus_ready_s(bus_ready_s),
    .s_ready(s_ready), .s_data_in(s_data_in), .s_valid_out(s_valid_out), .s_hold(s_hold),
    .state(state), .grant_id(grant_id), .decode_err(decode_err), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input int last, input logic [NM-1:0] req);
    for (int k = 1; k <= NM; k++)
      if (req[(last + k) % NM]) return (last + k) % NM;
    return -1;
  endfunction

  function automatic logic [NM-1:0] moh(input int i);
    logic [NM-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NS-1:0] soh(input int i);
    logic [NS-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic send_sel(input int m, input int val);
    for (int b = SW - 1; b >= 0; b--) begin
      m_address[m]       = val[b];
      m_address_valid[m] = 1'b1;
      tick();
    end
    m_address_valid[m] = 1'b0;
    m_address[m]       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    reset = 0;
    lg = NM - 1;
    checks++;
    if (state !== 2'd0 || m_available !== '0 || grant_id !== 3'd0 || bus_ready_s !== '0 ||
        decode_err !== 1'b0 || timeout_err !== 1'b0 || m_data_out !== '0 || s_data !== '0) begin
      errors++;
      $display("FAIL reset: state=%0d avail=%b gid=%0d brs=%b derr=%b terr=%b, want all 0",
               state, m_available, grant_id, bus_ready_s, decode_err, timeout_err);
    end
  endtask

  task automatic test_first_grant();
    m_request = 4'b0101;
    tick();
    checks++;
    if (m_available !== 4'b0001 || state !== 2'd1 || grant_id !== 3'd0) begin
      errors++; $display("FAIL first_grant: avail=%b state=%0d gid=%0d, want 0001/1/0", m_available, state, grant_id);
    end
    send_sel(0, 2);
    checks++;
    if (state !== 2'd2 || bus_ready_s !== 3'b100) begin
      errors++; $display("FAIL connect_sel2: state=%0d brs=%b, want 2/100", state, bus_ready_s);
    end
    m_request[0] = 0;
    tick();
    lg = 0;
    checks++;
    if (state !== 2'd0 || m_available !== '0 || bus_ready_s !== '0) begin
      errors++; $display("FAIL release0: state=%0d avail=%b brs=%b, want 0/0/0", state, m_available, bus_ready_s);
    end
    tick();
    checks++;
    if (m_available !== moh(rr_pick(lg, 4'b0100)) || grant_id !== 3'd2) begin
      errors++; $display("FAIL next_grant: avail=%b gid=%0d, want 0100/2", m_available, grant_id);
    end
    m_request = '0;
    tick();
    lg = 2;
    checks++;
    if (state !== 2'd0 || decode_err !== 1'b0) begin
      errors++; $display("FAIL abort: state=%0d derr=%b, want 0/0", state, decode_err);
    end
  endtask

  task automatic test_routing();
    int bad = 0;
    m_request = 4'b0010;
    tick();
    checks++;
    if (grant_id !== 3'(rr_pick(lg, 4'b0010))) begin
      errors++; $display("FAIL route_grant: gid=%0d want 1", grant_id);
    end
    send_sel(1, 1);
    checks++;
    if (bus_ready_s !== 3'b010) begin
      errors++; $display("FAIL route_brs: brs=%b want 010", bus_ready_s);
    end
    for (int i = 0; i < 8; i++) begin
      s_data_in = 3'($urandom); s_ready = 3'($urandom); s_valid_out = 3'($urandom);
      m_data = 4'($urandom); m_valid = 4'($urandom); m_write_en = 4'($urandom);
      m_data[1] = i[0];
      #1;
      if (m_data_out !== (s_data_in[1] ? 4'b0010 : 4'b0000) ||
          m_ready !== (s_ready[1] ? 4'b0010 : 4'b0000) ||
          m_valid_in !== (s_valid_out[1] ? 4'b0010 : 4'b0000) ||
          s_data !== (m_data[1] ? 3'b010 : 3'b000) ||
          s_valid !== (m_valid[1] ? 3'b010 : 3'b000) ||
          s_write_en !== (m_write_en[1] ? 3'b010 : 3'b000)) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL route_data: %0d bad cycles, want 0", bad);
    end
    m_data = '0; m_valid = '0; m_write_en = '0; s_data_in = '0; s_ready = '0; s_valid_out = '0;
    m_request = '0;
    tick();
    lg = 1;
  endtask

  task automatic test_decode();
    m_request = 4'b0001;
    tick();
    send_sel(0, 3);
    checks++;
    if (decode_err !== 1'b1 || state !== 2'd0 || bus_ready_s !== '0 || m_available !== '0) begin
      errors++; $display("FAIL decode: derr=%b state=%0d brs=%b avail=%b, want 1/0/000/0000",
                         decode_err, state, bus_ready_s, m_available);
    end
    lg = 0;
    m_request = '0;
    tick();
    checks++;
    if (decode_err !== 1'b0 || state !== 2'd0) begin
      errors++; $display("FAIL decode_pulse: derr=%b state=%0d, want 0/0", decode_err, state);
    end
  endtask

  task automatic test_hold();
    int hc = 0;
    m_request = 4'b0001;
    tick();
    send_sel(0, 2);
    m_request[3] = 1;
    s_hold = 3'b100;
    m_request[0] = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (state == 2'd3 && m_available == 4'b0001 && bus_ready_s == 3'b100) hc++;
      if (i == 4) s_hold = '0;
      tick();
    end
    lg = 0;
    checks++;
    if (hc != 5 || state !== 2'd0) begin
      errors++; $display("FAIL hold: hold_cycles=%0d state=%0d, want 5/0", hc, state);
    end
    tick();
    checks++;
    if (grant_id !== 3'(rr_pick(lg, 4'b1000)) || m_available !== 4'b1000) begin
      errors++; $display("FAIL after_hold: gid=%0d avail=%b, want 3/1000", grant_id, m_available);
    end
    m_request = '0;
    tick();
    lg = 3;
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      logic [NM-1:0] req;
      int exp, sv, bad;
      req = NM'($urandom_range(1, 15));
      m_request = req;
      tick();
      exp = rr_pick(lg, req);
      checks++;
      if (grant_id !== 3'(exp) || m_available !== moh(exp)) begin
        errors++; $display("FAIL rand_grant[%0d]: gid=%0d avail=%b req=%b, want %0d", t, grant_id, m_available, req, exp);
      end
      sv = $urandom_range(0, 3);
      send_sel(exp, sv);
      if (sv >= NS) begin
        checks++;
        if (decode_err !== 1'b1 || state !== 2'd0) begin
          errors++; $display("FAIL rand_decode[%0d]: derr=%b state=%0d, want 1/0", t, decode_err, state);
        end
      end else begin
        bad = 0;
        for (int c = 0; c < $urandom_range(1, 4); c++) begin
          m_data = 4'($urandom); s_data_in = 3'($urandom);
          #1;
          if (m_data_out !== (s_data_in[sv] ? moh(exp) : '0) || s_data !== (m_data[exp] ? soh(sv) : '0) ||
              grant_id !== 3'(exp) || bus_ready_s !== soh(sv)) bad++;
          tick();
        end
        checks++;
        if (bad != 0) begin
          errors++; $display("FAIL rand_route[%0d]: %0d bad cycles, want 0", t, bad);
        end
        m_request[exp] = 0;
        tick();
        checks++;
        if (state !== 2'd0) begin
          errors++; $display("FAIL rand_release[%0d]: state=%0d want 0", t, state);
        end
      end
      lg = exp;
      m_request = '0; m_data = '0; s_data_in = '0;
      tick();
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    m_request = 4'b0010;
    tick();
    send_sel(1, 0);
    n = 2;
    m_request[2] = 1;
`ifdef ARB_TIMEOUT_EN
    while (!timeout_err && n < 40) begin
      tick();
      n++;
    end
    lg = 1;
    checks++;
    if (n != 20 || timeout_err !== 1'b1 || state !== 2'd0) begin
      errors++; $display("FAIL timeout: cycles=%0d terr=%b state=%0d, want 20/1/0", n, timeout_err, state);
    end
    tick();
    checks++;
    if (grant_id !== 3'(rr_pick(lg, 4'b0110))) begin
      errors++; $display("FAIL timeout_next: gid=%0d want 2", grant_id);
    end
    m_request = '0;
    tick();
    lg = 2;
`else
    begin
      int bad = 0;
      for (int i = 0; i < 60; i++) begin
        if (state != 2'd2 || grant_id != 3'd1 || timeout_err != 1'b0) bad++;
        tick();
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL no_timeout: %0d cycles lost grant, want 0", bad);
      end
    end
    m_request = '0;
    tick();
    lg = 1;
`endif
  endtask

  task automatic test_reset_mid();
    m_request = 4'b0001;
    tick();
    send_sel(0, 1);
    m_data = '1; s_data_in = '1; s_ready = '1;
    reset = 1;
    tick();
    checks++;
    if (state !== 2'd0 || m_available !== '0 || bus_ready_s !== '0 || m_data_out !== '0 ||
        s_data !== '0 || m_ready !== '0 || grant_id !== 3'd0) begin
      errors++; $display("FAIL reset_mid: state=%0d avail=%b brs=%b mdo=%b sd=%b, want all 0",
                         state, m_available, bus_ready_s, m_data_out, s_data);
    end
    reset = 0;
    lg = NM - 1;
    m_data = '0; s_data_in = '0; s_ready = '0;
    m_request = 4'b1111;
    tick();
    checks++;
    if (grant_id !== 3'(rr_pick(lg, 4'b1111)) || m_available !== 4'b0001) begin
      errors++; $display("FAIL reset_regrant: gid=%0d avail=%b, want 0/0001", grant_id, m_available);
    end
    m_request = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_routing();
    test_decode();
    test_hold();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
